// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback arbiter bus: ALU/MDU sources, register-file write port, pending-write lookup
interface regfile_wb_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic [4:0]  writereg;
    logic [31:0] writedata;
    logic        RegWrite;
    logic [4:0]  pend_rd_a;
    logic [4:0]  pend_rd_b;
    logic        pend_hit_a;
    logic        pend_hit_b;
    logic        alu_stall;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mdu_valid, mdu_rd, mdu_data,
        output pend_rd_a, pend_rd_b,
        input  mdu_ready, writereg, writedata, RegWrite,
        input  pend_hit_a, pend_hit_b, alu_stall
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mdu_valid, mdu_rd, mdu_data,
        input  pend_rd_a, pend_rd_b,
        output mdu_ready, writereg, writedata, RegWrite,
        output pend_hit_a, pend_hit_b, alu_stall
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - merges ALU pipeline and buffered MDU results onto one regfile write port; optional WB_STARVE_GUARD_EN
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  wb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       q_rd   [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        alu_req;
    logic        alu_grant;
    logic        stall;
    logic        we_q;
    logic [4:0]  rd_q;
    logic [31:0] data_q;
    logic        hit_a;
    logic        hit_b;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(DEPTH));
    // x0 results complete their handshake but never occupy a slot
    assign push       = wb.mdu_valid && !fifo_full && (wb.mdu_rd != 5'd0);
    assign alu_req    = wb.alu_valid && (wb.alu_rd != 5'd0);
    assign alu_grant  = alu_req && !stall;
    assign pop        = !alu_grant && !fifo_empty;

    assign wb.mdu_ready  = !fifo_full;
    assign wb.alu_stall  = stall;
    assign wb.RegWrite   = we_q;
    assign wb.writereg   = rd_q;
    assign wb.writedata  = data_q;
    assign wb.pend_hit_a = hit_a;
    assign wb.pend_hit_b = hit_b;

`ifdef WB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    logic [SC_W-1:0] starve_cnt;

    assign stall = (starve_cnt == SC_W'(STARVE_LIMIT));

    // Count cycles the buffered head loses to the ALU; any pop or empty FIFO restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (pop || fifo_empty) begin
            starve_cnt <= '0;
        end else if (alu_grant) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign stall = 1'b0;
`endif

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= wb.mdu_rd;
            q_data[wr_ptr] <= wb.mdu_data;
        end
    end

    // Registered write port: ALU first, then FIFO head; address/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            rd_q   <= 5'd0;
            data_q <= 32'd0;
        end else if (alu_grant) begin
            we_q   <= 1'b1;
            rd_q   <= wb.alu_rd;
            data_q <= wb.alu_data;
        end else if (pop) begin
            we_q   <= 1'b1;
            rd_q   <= q_rd[rd_ptr];
            data_q <= q_data[rd_ptr];
        end else begin
            we_q   <= 1'b0;
        end
    end

    // Pending lookup over the live FIFO entries only; the output register is already committed
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                if ((wb.pend_rd_a != 5'd0) && (q_rd[rd_ptr + PTR_W'(i)] == wb.pend_rd_a)) hit_a = 1'b1;
                if ((wb.pend_rd_b != 5'd0) && (q_rd[rd_ptr + PTR_W'(i)] == wb.pend_rd_b)) hit_b = 1'b1;
            end
        end
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Writeback-side driver for the 32x32 register file's single synchronous write port. Merges two result producers onto one write port:
- the in-order ALU/load pipeline (fixed-latency, highest priority)
- a long-latency multiply/divide unit (valid/ready handshake, buffered in a small FIFO)

Outputs are registered on posedge clk, so the register file's negedge write samples stable values. Also exposes a pending-write lookup so decode/hazard logic can stall on registers still queued for writeback.

Parameters:
DEPTH, 4, FIFO entries for long-latency results; power of two, 2..16.
STARVE_LIMIT, 8, consecutive blocked cycles before the FIFO head is forced through; used only with the optional feature.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst_n  input  1  asynchronous, active-low reset.
alu_valid  input  1  pipeline result valid this cycle.
alu_rd  input  5  pipeline destination register.
alu_data  input  32  pipeline result.
mdu_valid  input  1  long-latency result offered.
mdu_ready  output  1  FIFO can accept; equals not-full.
mdu_rd  input  5  long-latency destination register.
mdu_data  input  32  long-latency result.
writereg  output  5  register-file write address.
writedata  output  32  register-file write data.
RegWrite  output  1  register-file write enable; one-cycle pulse per write.
pend_rd_a  input  5  pending-write query A.
pend_rd_b  input  5  pending-write query B.
pend_hit_a  output  1  pend_rd_a has a buffered write.
pend_hit_b  output  1  pend_rd_b has a buffered write.
alu_stall  output  1  upstream must hold its ALU result this cycle.

Behaviour:
- Reset (async, rst_n=0):
  - writereg=0, writedata=0, RegWrite=0, alu_stall=0
  - FIFO empty, so mdu_ready=1
  - pend_hit_a=pend_hit_b=0
  - starve counter=0
  - Reset asserted mid-operation discards all queued entries; nothing is written afterwards.
- x0 filter:
  - alu_valid with alu_rd=0: ignored, and RegWrite stays 0 for it.
  - mdu handshake with mdu_rd=0: completes but is not enqueued.
- Enqueue: on posedge, if mdu_valid & mdu_ready & mdu_rd!=0, push {mdu_rd, mdu_data}.
  - mdu_ready depends only on FIFO occupancy, never on mdu_valid.
  - When full, mdu_ready=0 and the producer holds its data.
- Grant per cycle, evaluated combinationally and registered at posedge:
  1. alu_valid & alu_rd!=0 & !alu_stall: ALU wins. Next-cycle outputs are RegWrite=1, writereg=alu_rd, writedata=alu_data. FIFO head holds.
  2. Otherwise, if the FIFO is non-empty: pop the head. Next-cycle outputs are RegWrite=1 with the head's rd and data.
  3. Otherwise: RegWrite=0 next cycle. writereg/writedata hold their last values.
- Latency:
  - ALU: one cycle from input to RegWrite.
  - MDU: at least two cycles (enqueue edge, then dequeue edge).
- Push and pop in the same cycle: allowed. Occupancy is unchanged and the pushed entry goes behind the head. A value pushed on the same edge is never popped on that edge.
- Pointers: log2(DEPTH)-bit read/write pointers, wrapping modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits; full when count==DEPTH.
- Pending lookup (combinational):
  - pend_hit_x=1 iff pend_rd_x!=0 and it matches the rd of any valid FIFO entry.
  - The output register is not included, because the register file has committed it by the next posedge.
- Ordering between sources is grant order. Upstream guarantees via pend_hit that no younger ALU write targets an rd still pending in the FIFO.

Optional Feature:
Macro: WB_STARVE_GUARD_EN.
- Defined:
  - The counter increments each cycle the FIFO is non-empty and the ALU wins the grant.
  - The counter clears on any FIFO pop or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, alu_stall=1 for the next cycle.
  - In that cycle the FIFO head is granted, any ALU request is not written, and upstream re-presents it.
  - The counter then clears.
- Not defined: alu_stall is tied to 0, the counter is absent, and ALU always wins.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> RegWrite=0, mdu_ready=1, pend_hit_a=0, writereg=0.
- ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at edge N -> cycle N+1 shows RegWrite=1, writereg=5, writedata=0xDEADBEEF; RegWrite=0 at N+2. Repeat with alu_rd=0 -> no RegWrite.
- MDU contention: ALU writes r1..r3 on three consecutive cycles while MDU pushes rd=9 data=0x1234 in the first of them -> three ALU writes appear first, then rd=9 one cycle later. pend_hit_a (pend_rd_a=9) is 1 until the pop, then 0.
- FIFO full: with DEPTH=4 and ALU continuously busy, push 4 MDU results -> mdu_ready=0 and a 5th offer stalls. Release ALU -> entries drain in push order, mdu_ready returns to 1 after the first pop.
- Wrap/simultaneous: push/pop every cycle for 10 cycles -> pointers wrap, writes appear in exact push order, occupancy constant.
- Starve guard (macro defined, STARVE_LIMIT=8): FIFO holds rd=7 while alu_valid is held 1 with distinct rds -> alu_stall=1 exactly on the 9th cycle, rd=7 written the next cycle, counter clears. Without the macro, rd=7 is never written while ALU stays busy.
